// File: rtl/prng128_pkg.sv
// Shared definitions for the 128-bit PRNG output path.
//   PRNG_DATA_W  : width of one PCG generator output
//   PRNG_OUT_W   : width of the concatenated {pcg1, pcg2} word
//   PRNG_WARMUP  : post-reset samples to discard (lcg + permutation latency)
//   state_t      : warm-up FSM encoding
package prng128_pkg;

    localparam int PRNG_DATA_W = 64;
    localparam int PRNG_OUT_W  = 2 * PRNG_DATA_W;
    localparam int PRNG_WARMUP = 4;

    typedef enum logic {
        ST_WARMUP = 1'b0,
        ST_RUN    = 1'b1
    } state_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Generic first-word-fall-through FIFO, DEPTH x WIDTH.
//   clk, rst  : clock, synchronous active-high reset (flushes pointers/level)
//   push      : write wr_data this cycle (caller guarantees !full || pop)
//   wr_data   : write data
//   pop       : consume head this cycle (ignored while empty)
//   rd_data   : head entry, 0 while empty
//   rd_valid  : FIFO non-empty
//   full      : level == DEPTH
//   level     : occupancy 0..DEPTH
module sync_fifo_fwft #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 128,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int LVL_W = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             full,
    output logic [LVL_W-1:0] level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             empty;
    logic             do_pop;

    assign empty    = (level == '0);
    assign full     = (level == LVL_W'(DEPTH));
    assign rd_valid = !empty;
    assign rd_data  = empty ? '0 : mem[rd_ptr];
    assign do_pop   = pop && !empty;

    // Storage is not reset; only the bookkeeping is.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

    // DEPTH is a power of two, so pointer wrap is the natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push && !do_pop)
                level <= level + LVL_W'(1);
            else if (do_pop && !push)
                level <= level - LVL_W'(1);
        end
    end

endmodule

// File: rtl/prng128_out_fifo.sv
// Output stage of the 128-bit PRNG: discards the generators' warm-up
// samples, packs {rand_a, rand_b} and buffers it in a FWFT FIFO.
// The generators never stall; a sample arriving while the FIFO is full
// (and nothing pops) is dropped and counted.
//   clk, rst      : clock, synchronous active-high reset (shared with pcg1/2)
//   rand_a/rand_b : pcg1/pcg2 outputs, sampled every cycle
//   out_data      : head word {rand_a, rand_b}, 0 when empty
//   out_valid     : head valid (FIFO non-empty)
//   out_ready     : consumer accepts head this cycle
//   fifo_level    : occupancy 0..DEPTH
//   overflow_cnt  : dropped samples, saturating
//   warm          : warm-up complete
module prng128_out_fifo
    import prng128_pkg::*;
#(
    parameter int DATA_W = PRNG_DATA_W,
    parameter int DEPTH  = 4,
    parameter int WARMUP = PRNG_WARMUP,
    parameter int CNT_W  = 16,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   rand_a,
    input  logic [DATA_W-1:0]   rand_b,
    output logic [2*DATA_W-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LVL_W-1:0]    fifo_level,
    output logic [CNT_W-1:0]    overflow_cnt,
    output logic                warm
);

    localparam int              WC_W    = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam logic [WC_W-1:0] WC_INIT = (WARMUP == 0) ? '0 : WC_W'(WARMUP - 1);

    state_t          state;
    logic [WC_W-1:0] wcnt;
    logic            full;
    logic            pop;
    logic            push;

    // Warm-up: count WARMUP cycles from reset, then run until the next reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= (WARMUP == 0) ? ST_RUN : ST_WARMUP;
            warm  <= (WARMUP == 0);
            wcnt  <= WC_INIT;
        end else begin
            case (state)
                ST_WARMUP: begin
                    if (wcnt == '0) begin
                        state <= ST_RUN;
                        warm  <= 1'b1;
                    end else begin
                        wcnt <= wcnt - WC_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // A pop frees a slot in the same cycle, so a full FIFO still accepts.
    assign pop  = out_valid && out_ready;
    assign push = (state == ST_RUN) && (!full || pop);

    always_ff @(posedge clk) begin
        if (rst)
            overflow_cnt <= '0;
        else if (state == ST_RUN && full && !pop && overflow_cnt != '1)
            overflow_cnt <= overflow_cnt + CNT_W'(1);
    end

    sync_fifo_fwft #(
        .DEPTH (DEPTH),
        .WIDTH (2 * DATA_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .wr_data  ({rand_a, rand_b}),
        .pop      (pop),
        .rd_data  (out_data),
        .rd_valid (out_valid),
        .full     (full),
        .level    (fifo_level)
    );

endmodule
